// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock.
// Operands and result each use a valid/ready handshake.
// Optional macro SEQ_MUL_SIGNED_EN adds an `sgn` input that selects
// two's-complement radix-2 Booth recoding per transaction.
// Without the macro the block is unsigned only.
module seq_shift_add_multiplier #(
  parameter int MULTIPLICAND_WID = 32,
  parameter int MULTIPLIER_WID   = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [MULTIPLICAND_WID-1:0]                M,
  input  logic [MULTIPLIER_WID-1:0]                  Q,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic                                       sgn,
`endif
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [MULTIPLICAND_WID+MULTIPLIER_WID-1:0] product,
  output logic                                       busy
);

  localparam int MW      = MULTIPLICAND_WID;
  localparam int QW      = MULTIPLIER_WID;
  localparam int PW      = MW + QW;
  localparam int CNT_WID = $clog2(MULTIPLIER_WID + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  // Datapath registers.
  // The accumulator carries one extra bit, so an add never loses its carry
  // and a Booth subtract of the most negative M still fits.
  logic [MW-1:0]      m_reg;
  logic [MW:0]        acc;
  logic [QW-1:0]      q_reg;
  logic [CNT_WID-1:0] cnt;
`ifdef SEQ_MUL_SIGNED_EN
  logic               sgn_reg;
  logic               q_prev;
`endif

  logic          accept;
  logic          last_step;
  logic          out_fire;
  logic [MW:0]   m_ext;
  logic [MW:0]   sum;
  logic          fill;
  logic [MW:0]   acc_nxt;
  logic [QW-1:0] q_nxt;

  assign accept    = in_valid && (state == IDLE);
  assign out_fire  = out_ready && (state == DONE);
  assign last_step = (cnt == CNT_WID'(QW - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // RUN lasts exactly QW edges. There is no early exit on zero operands.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_fire)  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs, decoded purely from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

`ifdef SEQ_MUL_SIGNED_EN
  // One step of the iteration.
  // Booth pair {q[0], q_prev} picks subtract/add/nothing in signed mode.
  // Plain shift-add on q[0] in unsigned mode.
  // Signed mode shifts the sign bit in (arithmetic shift).
  always_comb begin
    m_ext = sgn_reg ? {m_reg[MW-1], m_reg} : {1'b0, m_reg};
    sum   = acc;
    if (sgn_reg) begin
      unique case ({q_reg[0], q_prev})
        2'b10:   sum = acc - m_ext;
        2'b01:   sum = acc + m_ext;
        default: sum = acc;
      endcase
    end else if (q_reg[0]) begin
      sum = acc + m_ext;
    end
    fill    = sgn_reg ? sum[MW] : 1'b0;
    acc_nxt = {fill, sum[MW:1]};
    q_nxt   = {sum[0], q_reg[QW-1:1]};
  end
`else
  // One step of the iteration: conditional add of M, then shift {acc, q} right.
  // The accumulator top bit is always clear before the add, so the sum fits.
  always_comb begin
    m_ext   = {1'b0, m_reg};
    sum     = q_reg[0] ? (acc + m_ext) : acc;
    fill    = 1'b0;
    acc_nxt = {fill, sum[MW:1]};
    q_nxt   = {sum[0], q_reg[QW-1:1]};
  end
`endif

  // Operand capture on accept, then one shift-add step per RUN cycle.
  // Operands are taken only at the accept edge.
  // Later changes on M/Q do not reach the in-flight product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg   <= '0;
      acc     <= '0;
      q_reg   <= '0;
      cnt     <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      sgn_reg <= 1'b0;
      q_prev  <= 1'b0;
`endif
    end else if (accept) begin
      m_reg   <= M;
      acc     <= '0;
      q_reg   <= Q;
      cnt     <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      sgn_reg <= sgn;
      q_prev  <= 1'b0;
`endif
    end else if (state == RUN) begin
      acc     <= acc_nxt;
      q_reg   <= q_nxt;
      cnt     <= cnt + CNT_WID'(1);
`ifdef SEQ_MUL_SIGNED_EN
      q_prev  <= q_reg[0];
`endif
    end
  end

  // Result register.
  // Loaded on the final step and held through DONE back-pressure.
  // The low PW bits of {acc, q} are the full product.
  // In signed mode the accumulator top bit is only sign extension.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                product <= '0;
    else if ((state == RUN) && last_step)   product <= PW'({acc_nxt[MW-1:0], q_nxt});
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier (32x32 build).
// Each issued request pushes its hand-computed product into a queue.
// A negedge monitor pops and compares on every output handshake.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] M;
  logic [31:0] Q;
`ifdef SEQ_MUL_SIGNED_EN
  logic        sgn;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc   = 0;
  logic [63:0] exp_q[$];
  int          acc_log[$];

  seq_shift_add_multiplier #(.MULTIPLICAND_WID(32), .MULTIPLIER_WID(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M         (M),
    .Q         (Q),
`ifdef SEQ_MUL_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected product.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_product: got %h expected none", product);
      end else begin
        check("product", product, exp_q.pop_front());
      end
    end
  end

  // Accept logger for the throughput check.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) acc_log.push_back(cyc);
  end

  // Returns one time unit after the accept edge with in_valid low.
  // M/Q/sgn are scrambled afterwards to show they are not re-sampled.
  task automatic issue(input logic [31:0] m, input logic [31:0] q, input logic s,
                       input bit push, input logic [63:0] e);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("issue_ready", {63'd0, in_ready}, 64'd1);
    M = m; Q = q; in_valid = 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
    sgn = s;
`endif
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    M = 32'hA5A5A5A5; Q = 32'h5A5A5A5A;
`ifdef SEQ_MUL_SIGNED_EN
    sgn = ~s;
`endif
  endtask

  task automatic wait_out(output int lat);
    int n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid) begin
      n_cmp++; n_mis++;
      $display("FAIL out_valid_timeout: got 0 expected 1 within 100 cycles");
    end
    lat = n;
  endtask

  // With out_ready high, the handshake edge returns the block to IDLE.
  task automatic drain();
    @(posedge clk); #1;
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);
    check("drain_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_one(input string name, input logic [31:0] m, input logic [31:0] q,
                         input logic s, input logic [63:0] e);
    int lat;
    issue(m, q, s, 1'b1, e);
    wait_out(lat);
    check(name, 64'(lat), 64'd32);
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    rst = 1'b1; in_valid = 1'b0; M = '0; Q = '0; out_ready = 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
    sgn = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_product", product, 64'd0);
    rst = 1'b0;

    // 16 x 16: latency and handshake status.
    issue(32'd16, 32'd16, 1'b0, 1'b1, 64'd256);
    check("accept_in_ready", {63'd0, in_ready}, 64'd0);
    check("accept_busy", {63'd0, busy}, 64'd1);
    wait_out(lat);
    check("latency_16x16", 64'(lat), 64'd32);
    check("done_busy", {63'd0, busy}, 64'd0);
    drain();

    // 6 x 2 under back-pressure, with ignored in_valid pulses.
    out_ready = 1'b0;
    issue(32'd6, 32'd2, 1'b0, 1'b1, 64'd12);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      check("hold_product", product, 64'd12);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      in_valid = i[0]; M = 32'd99; Q = 32'd77;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Boundaries: all-ones and zero operand.
    run_one("latency_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
    run_one("latency_zero", 32'd0, 32'd23, 1'b0, 64'd0);

    // Back-to-back stream with in_valid held high.
    acc_log.delete();
    M = 32'd16; Q = 32'd23; in_valid = 1'b1;
    exp_q.push_back(64'd368);
    n = 0;
    while (in_ready && n < 10) begin @(posedge clk); #1; n++; end
    M = 32'd13; Q = 32'd12;
    exp_q.push_back(64'd156);
    n = 0;
    while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
    n = 0;
    while (in_ready && n < 10) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    wait_out(lat);
    drain();
    check("accept_count", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() == 2) check("accept_spacing", 64'(acc_log[1] - acc_log[0]), 64'd34);

    // Reset at step 10 of 7 x 9: aborted, then rerun.
    issue(32'd7, 32'd9, 1'b0, 1'b0, 64'd0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_product", product, 64'd0);
    @(posedge clk); #1;
    check("abort_hold_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
    run_one("latency_7x9", 32'd7, 32'd9, 1'b0, 64'd63);

`ifdef SEQ_MUL_SIGNED_EN
    run_one("latency_s_m3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1);
    run_one("latency_s_5xm3", 32'd5, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFF1);
    run_one("latency_s_min", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
    run_one("latency_u_min", 32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000);
    run_one("latency_u_m3x5", 32'hFFFFFFFD, 32'd5, 1'b0, 64'h00000004_FFFFFFF1);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
